wb_fir_host_master: RTL and testbench
=====================================

// Module: wb_fir_host_master
// PURPOSE
//  Wishbone initiator that drives the FIR user-project slave (AXI-Lite config, X stream at 0x40,
//  Y stream at 0x44, user BRAM at 0x3800_0000) from a simple command/response interface.
//  Issues single or burst (fixed or incrementing address) classic WB cycles, one beat at a time,
//  with a per-beat ack timeout. Sits in the testbench/host side, or in a DMA-style sequencer.
// PARAMETERS
//  ADDR_WIDTH  32  Wishbone address width
//  DATA_WIDTH  32  Wishbone data width (sel width = DATA_WIDTH/8)
//  LEN_WIDTH   8   burst length field width; beats = cmd_len+1 (1..2^LEN_WIDTH)
//  TIMEOUT     64  max cycles a beat waits for ack before abort (>=1)
// PORTS
//  wb_clk_i     in   1    clock
//  wb_rst_i     in   1    asynchronous reset, active-high
//  cmd_valid    in   1    command offered
//  cmd_ready    out  1    command accepted when valid&ready
//  cmd_we       in   1    1=write, 0=read
//  cmd_adr      in   ADDR_WIDTH   start byte address
//  cmd_dat      in   DATA_WIDTH   write data (same value every beat)
//  cmd_sel      in   DATA_WIDTH/8 byte selects
//  cmd_len      in   LEN_WIDTH    beats-1
//  cmd_inc      in   1    1=address += DATA_WIDTH/8 per beat, 0=fixed (stream ports)
//  rsp_valid    out  1    per-beat response valid
//  rsp_ready    in   1    response consumed
//  rsp_dat      out  DATA_WIDTH   read data (0 for writes)
//  rsp_err      out  1    beat timed out
//  rsp_last     out  1    final response of command
//  busy         out  1    command in progress
//  wbm_cyc_o / wbm_stb_o / wbm_we_o  out 1   WB control
//  wbm_adr_o    out  ADDR_WIDTH   WB address
//  wbm_sel_o    out  DATA_WIDTH/8 WB byte selects
//  wbm_dat_o    out  DATA_WIDTH   WB write data
//  wbm_ack_i    in   1    WB acknowledge
//  wbm_dat_i    in   DATA_WIDTH   WB read data
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0 incl. cyc/stb; cmd_ready rises 1st cycle after release.
//  FSM IDLE->BUS->RESP. All outputs registered.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready latch all cmd fields, beat counter=cmd_len,
//   cmd_ready=0, busy=1; next cycle cyc=stb=1 with adr/we/sel/dat driven (accept->bus latency 1).
//  BUS: cyc/stb/adr/we/sel/dat held stable until ack; timeout counter increments each BUS cycle.
//   ack: capture wbm_dat_i (reads), drop cyc/stb next edge, ->RESP with rsp_err=0.
//   counter reaches TIMEOUT without ack: drop cyc/stb, ->RESP with rsp_err=1, rsp_last=1, remaining beats abandoned.
//   ack and expiry same cycle: ack wins, no error.
//  RESP: rsp_valid=1, cyc/stb=0 (>=1 idle cycle between beats). rsp_last=1 on final beat or error.
//   rsp_valid&rsp_ready: if beats remain and no error -> BUS (adr += DATA_WIDTH/8 if cmd_inc,
//   wraps modulo 2^ADDR_WIDTH), counter cleared; else ->IDLE, busy=0, cmd_ready=1 next cycle.
//   rsp_ready low holds response stable indefinitely; no new bus beat issued.
//  ack outside BUS ignored. cmd_valid while busy ignored (not latched).
//  Reset mid-beat: cyc/stb drop asynchronously; pending response discarded.
// STRUCTURE
//  Package wb_host_pkg: state encoding (IDLE/BUS/RESP), BYTES=DATA_WIDTH/8, TO_W=$clog2(TIMEOUT+1).
//  Sub-module wbm_timeout_ctr (clear, enable, expired) instantiated once; rest in top.
// TESTING
//  1 single write 0x3000_0010 data 0x0000_0040, ack 2 cycles after stb -> one beat, rsp_last=1, rsp_err=0, dat=0.
//  2 single read 0x3000_0000, slave returns 0x0000_0004 -> rsp_dat=0x4, cyc high exactly until ack edge.
//  3 burst write len=63 inc=0 adr 0x3000_0040 -> 64 beats all at 0x40, stb low >=1 cycle between, last on beat 64.
//  4 burst read len=3 inc=1 adr 0x3800_0000 -> addresses 0x0,0x4,0x8,0xC; data in order; rsp_ready held low
//    5 cycles on beat 2 -> no stb until consumed.
//  5 TIMEOUT=16, no ack on beat 2 of len=3 -> stb drops after 16 BUS cycles, rsp_err=1, rsp_last=1,
//    beats 3-4 never issued; ack+expiry same cycle -> no error.
//  6 assert wb_rst_i during BUS of a burst -> cyc/stb 0 same cycle, rsp_valid=0, cmd_ready=1 one cycle after release.

Source files
------------

// File: rtl/wb_host_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wb_host_pkg
// Purpose  : Shared state encoding and sizing helpers for the Wishbone host.
// Revision : 1.0 - initial release
// ============================================================================
package wb_host_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int bytes_of(input int data_width);
      return data_width / 8;
   endfunction

   // Counter must be able to hold the value TIMEOUT itself
   function automatic int to_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wbm_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : wbm_timeout_ctr
// Purpose  : Per-beat ack watchdog; expired is high on the TIMEOUT-th cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wbm_timeout_ctr
   import wb_host_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = to_width(TIMEOUT)
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TO_W-1:0] r_cnt;

   // Saturates at TIMEOUT-1 so expired stays asserted until cleared
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         r_cnt <= '0;
      else if (clear)
         r_cnt <= '0;
      else if (enable && !expired)
         r_cnt <= r_cnt + 1'b1;
   end

   assign expired = (r_cnt == TO_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_fir_host_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_fir_host_master
// Purpose  : Command/response driven classic Wishbone initiator, one beat at a
//            time, with fixed/incrementing bursts and a per-beat ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fir_host_master
   import wb_host_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic [DATA_WIDTH-1:0]   cmd_dat,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic                    cmd_inc,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_dat,
   output logic                    rsp_err,
   output logic                    rsp_last,
   output logic                    busy,
   output logic                    wbm_cyc_o,
   output logic                    wbm_stb_o,
   output logic                    wbm_we_o,
   output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
   output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
   output logic [DATA_WIDTH-1:0]   wbm_dat_o,
   input  logic                    wbm_ack_i,
   input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);

   localparam int BYTES = bytes_of(DATA_WIDTH);

   state_t                  r_state, w_state;
   logic                    r_cmd_ready, w_cmd_ready;
   logic                    r_busy, w_busy;
   logic                    r_cyc, w_cyc;
   logic                    r_we, w_we;
   logic                    r_inc, w_inc;
   logic [ADDR_WIDTH-1:0]   r_adr, w_adr;
   logic [BYTES-1:0]        r_sel, w_sel;
   logic [DATA_WIDTH-1:0]   r_dat, w_dat;
   logic [LEN_WIDTH-1:0]    r_beats, w_beats;
   logic                    r_rsp_valid, w_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_dat, w_rsp_dat;
   logic                    r_rsp_err, w_rsp_err;
   logic                    r_rsp_last, w_rsp_last;
   logic                    w_expired;

   wbm_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .clear    (r_state != ST_BUS),
      .enable   ((r_state == ST_BUS) && !wbm_ack_i),
      .expired  (w_expired)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_cyc       <= 1'b0;
         r_we        <= 1'b0;
         r_inc       <= 1'b0;
         r_adr       <= '0;
         r_sel       <= '0;
         r_dat       <= '0;
         r_beats     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_dat   <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_last  <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cmd_ready <= w_cmd_ready;
         r_busy      <= w_busy;
         r_cyc       <= w_cyc;
         r_we        <= w_we;
         r_inc       <= w_inc;
         r_adr       <= w_adr;
         r_sel       <= w_sel;
         r_dat       <= w_dat;
         r_beats     <= w_beats;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_dat   <= w_rsp_dat;
         r_rsp_err   <= w_rsp_err;
         r_rsp_last  <= w_rsp_last;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_cmd_ready = r_cmd_ready;
      w_busy      = r_busy;
      w_cyc       = r_cyc;
      w_we        = r_we;
      w_inc       = r_inc;
      w_adr       = r_adr;
      w_sel       = r_sel;
      w_dat       = r_dat;
      w_beats     = r_beats;
      w_rsp_valid = r_rsp_valid;
      w_rsp_dat   = r_rsp_dat;
      w_rsp_err   = r_rsp_err;
      w_rsp_last  = r_rsp_last;
      case (r_state)
         ST_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid && r_cmd_ready) begin
               w_cmd_ready = 1'b0;
               w_busy      = 1'b1;
               w_cyc       = 1'b1;
               w_we        = cmd_we;
               w_inc       = cmd_inc;
               w_adr       = cmd_adr;
               w_sel       = cmd_sel;
               w_dat       = cmd_dat;
               w_beats     = cmd_len;
               w_state     = ST_BUS;
            end
         end
         ST_BUS: begin
            // Ack takes priority over a coincident expiry
            if (wbm_ack_i) begin
               w_cyc       = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_dat   = r_we ? '0 : wbm_dat_i;
               w_rsp_err   = 1'b0;
               w_rsp_last  = (r_beats == '0);
               w_state     = ST_RESP;
            end else if (w_expired) begin
               w_cyc       = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_dat   = '0;
               w_rsp_err   = 1'b1;
               w_rsp_last  = 1'b1;
               w_state     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid = 1'b0;
               w_rsp_err   = 1'b0;
               w_rsp_last  = 1'b0;
               if (!r_rsp_err && (r_beats != '0)) begin
                  w_beats = r_beats - 1'b1;
                  if (r_inc)
                     w_adr = r_adr + ADDR_WIDTH'(BYTES);
                  w_cyc   = 1'b1;
                  w_state = ST_BUS;
               end else begin
                  w_busy      = 1'b0;
                  w_cmd_ready = 1'b1;
                  w_state     = ST_IDLE;
               end
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;
   assign wbm_we_o  = r_we;
   assign wbm_adr_o = r_adr;
   assign wbm_sel_o = r_sel;
   assign wbm_dat_o = r_dat;
   assign rsp_valid = r_rsp_valid;
   assign rsp_dat   = r_rsp_dat;
   assign rsp_err   = r_rsp_err;
   assign rsp_last  = r_rsp_last;

endmodule
`default_nettype wire

// File: tb/tb_wb_fir_host_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_fir_host_master
// Purpose  : Self-checking bench for wb_fir_host_master against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_fir_host_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic            cmd_we = 1'b0;
   logic [AW-1:0]   cmd_adr = '0;
   logic [DW-1:0]   cmd_dat = '0;
   logic [DW/8-1:0] cmd_sel = '0;
   logic [LW-1:0]   cmd_len = '0;
   logic            cmd_inc = 1'b0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [DW-1:0]   rsp_dat;
   logic            rsp_err;
   logic            rsp_last;
   logic            busy;
   logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [AW-1:0]   wbm_adr_o;
   logic [DW/8-1:0] wbm_sel_o;
   logic [DW-1:0]   wbm_dat_o;
   logic            wbm_ack_i = 1'b0;
   logic [DW-1:0]   wbm_dat_i = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] mem [logic [AW-1:0]];

   wb_fir_host_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW),
      .TIMEOUT    (TO)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .cmd_sel   (cmd_sel),
      .cmd_len   (cmd_len),
      .cmd_inc   (cmd_inc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err),
      .rsp_last  (rsp_last),
      .busy      (busy),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (wbm_ack_i),
      .wbm_dat_i (wbm_dat_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (!mem.exists(a))
         mem[a] = $urandom;
      return mem[a];
   endfunction

   function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [DW/8-1:0] s);
      logic [DW-1:0] old;
      old = model_read(a);
      for (int i = 0; i < DW/8; i++)
         if (s[i]) old[8*i +: 8] = d[8*i +: 8];
      mem[a] = old;
   endfunction

   // One command end to end. Beat b acks after dly stb cycles (ack on cycle dly+1);
   // to_beat never acks; hold_beat keeps rsp_ready low for hold_n cycles.
   task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [DW/8-1:0] sel, input int len, input logic inc,
                          input int dfix, input int dmax, input int to_beat,
                          input int hold_beat, input int hold_n);
      int guard, d, hold;
      logic acked, last_exp;
      logic [AW-1:0] a;
      logic [DW-1:0] rd_exp;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      cmd_len = LW'(len); cmd_inc = inc; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      chk("cmd_ready_after_accept", cmd_ready, 1'b0);
      for (int b = 0; b <= len; b++) begin
         a = inc ? adr + AW'(4 * b) : adr;
         d = (b == to_beat) ? 1000 : ((dfix >= 0) ? dfix : int'($urandom_range(dmax, 0)));
         rd_exp = we ? '0 : model_read(a);
         chk("cyc_start", wbm_cyc_o, 1'b1);
         chk("stb_start", wbm_stb_o, 1'b1);
         chk("adr", wbm_adr_o, a);
         chk("we", wbm_we_o, we);
         chk("sel", wbm_sel_o, sel);
         if (we) chk("wdat", wbm_dat_o, dat);
         for (int k = 1; k <= TO; k++) begin
            if (k > 1) begin
               chk("stb_held", wbm_stb_o, 1'b1);
               chk("adr_held", wbm_adr_o, a);
            end
            cmd_valid = (k % 2 == 0);
            cmd_adr   = $urandom;
            if (k == d + 1) begin
               wbm_ack_i = 1'b1;
               wbm_dat_i = we ? DW'($urandom) : rd_exp;
            end else begin
               wbm_ack_i = 1'b0;
               wbm_dat_i = $urandom;
            end
            @(negedge clk);
            if (wbm_ack_i) break;
         end
         acked = (d + 1 <= TO);
         wbm_ack_i = 1'b0;
         cmd_valid = 1'b0;
         if (we && acked) model_write(a, dat, sel);
         last_exp = !acked || (b == len);
         chk("cyc_drop", wbm_cyc_o, 1'b0);
         chk("stb_drop", wbm_stb_o, 1'b0);
         chk("rsp_valid", rsp_valid, 1'b1);
         chk("rsp_err", rsp_err, !acked);
         chk("rsp_last", rsp_last, last_exp);
         if (acked) chk("rsp_dat", rsp_dat, rd_exp);
         hold = (b == hold_beat) ? hold_n : int'($urandom_range(2, 0));
         for (int h = 0; h < hold; h++) begin
            wbm_ack_i = 1'b1;
            @(negedge clk);
            chk("rsp_hold_valid", rsp_valid, 1'b1);
            chk("rsp_hold_nostb", wbm_stb_o, 1'b0);
            if (acked) chk("rsp_hold_dat", rsp_dat, rd_exp);
         end
         wbm_ack_i = 1'b0;
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         if (last_exp) begin
            chk("busy_done", busy, 1'b0);
            chk("cmd_ready_done", cmd_ready, 1'b1);
            chk("rsp_valid_done", rsp_valid, 1'b0);
            chk("cyc_done", wbm_cyc_o, 1'b0);
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      #3;
      chk("rst_cyc", wbm_cyc_o, 1'b0);
      chk("rst_stb", wbm_stb_o, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
      chk("first_cmd_ready", cmd_ready, 1'b1);

      // Single write, single read
      run_cmd(1'b1, 32'h3000_0010, 32'h0000_0040, 4'hF, 0, 1'b0, 2, 0, -1, -1, 0);
      mem[32'h3000_0000] = 32'h0000_0004;
      run_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 1'b0, 1, 0, -1, -1, 0);

      // 64-beat fixed-address write to the X stream port
      run_cmd(1'b1, 32'h3000_0040, 32'hA5A5_0040, 4'hF, 63, 1'b0, -1, 4, -1, -1, 0);

      // Incrementing BRAM read with a stalled response on beat 2
      for (int i = 0; i < 4; i++) mem[32'h3800_0000 + 32'(4 * i)] = $urandom;
      run_cmd(1'b0, 32'h3800_0000, 32'h0, 4'hF, 3, 1'b1, -1, 3, -1, 1, 5);

      // Timeout on beat 2, then ack coinciding with expiry
      run_cmd(1'b0, 32'h3800_0000, 32'h0, 4'hF, 3, 1'b1, -1, 2, 1, -1, 0);
      run_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hF, 0, 1'b0, TO - 1, 0, -1, -1, 0);

      // Address wrap at the top of the space
      run_cmd(1'b1, 32'hFFFF_FFF8, 32'h1234_5678, 4'h5, 3, 1'b1, -1, 2, -1, -1, 0);

      for (int i = 0; i < 10; i++) begin
         logic rwe, rinc;
         int rlen, rto;
         rwe  = 1'($urandom);
         rinc = 1'($urandom);
         rlen = int'($urandom_range(5, 0));
         rto  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(rlen, 0)) : -1;
         run_cmd(rwe, AW'($urandom) & ~32'h3, DW'($urandom), 4'($urandom), rlen, rinc,
                 -1, 4, rto, -1, 0);
      end

      // Reset in the middle of a burst beat
      cmd_we = 1'b0; cmd_adr = 32'h3800_0000; cmd_sel = 4'hF;
      cmd_len = 8'd3; cmd_inc = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mid_rst_cyc_before", wbm_cyc_o, 1'b1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_cyc", wbm_cyc_o, 1'b0);
      chk("mid_rst_stb", wbm_stb_o, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rel_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
      chk("mid_rel_cmd_ready_up", cmd_ready, 1'b1);
      chk("mid_rel_cyc", wbm_cyc_o, 1'b0);
      run_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 1'b0, 0, 0, -1, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
